// File: rtl/tt_sweep_capture.sv
// Truth-table capture: sweeps all 2^N input codes of a function-under-test,
// records its output per code and counts the onset.
module tt_sweep_capture #(
    parameter int N       = 7,
    parameter int LATENCY = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [N-1:0]    x,
    input  logic            f_in,
    output logic            busy,
    output logic            done,
    output logic            valid,
    output logic [2**N-1:0] truth_table,
    output logic [N:0]      ones_count
);

    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [N-1:0] LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE
    } state_t;

    // state entered after every new x is driven
    localparam state_t S_AFTER = (LATENCY > 0) ? S_SETTLE : S_SAMPLE;

    state_t            r_state;
    state_t            w_next;
    logic [N-1:0]      r_idx;
    logic [N-1:0]      r_x;
    logic [CW-1:0]     r_cnt;
    logic [2**N-1:0]   r_tt;
    logic [N:0]        r_ones;
    logic              r_busy;
    logic              r_done;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && !abort) w_next = S_AFTER;
            end
            S_SETTLE: begin
                if (abort)                 w_next = S_IDLE;
                else if (r_cnt == CW'(1))  w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)              w_next = S_IDLE;
                else if (r_idx == LAST) w_next = S_IDLE;
                else                    w_next = S_AFTER;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_x     <= '0;
            r_cnt   <= '0;
            r_tt    <= '0;
            r_ones  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_idx   <= '0;
                        r_x     <= '0;
                        r_tt    <= '0;
                        r_ones  <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= CW'(LATENCY);
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_x     <= '0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_x     <= '0;
                    end else begin
                        r_tt[r_idx] <= f_in;
                        r_ones      <= r_ones + {{N{1'b0}}, f_in};
                        if (r_idx == LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_valid <= 1'b1;
                            r_x     <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_x   <= r_idx + 1'b1;
                            r_cnt <= CW'(LATENCY);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign x           = r_x;
    assign busy        = r_busy;
    assign done        = r_done;
    assign valid       = r_valid;
    assign truth_table = r_tt;
    assign ones_count  = r_ones;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Randomized bench for tt_sweep_capture: function-under-test is a table
// lookup, expected capture is that table and its popcount.
module tb_tt_sweep_capture;

    logic         clk = 1'b0;
    logic         rst;
    logic         start0, abort0, start2, abort2;
    logic [127:0] fn;
    logic         sel_dly;
    logic [6:0]   x0, x2;
    logic         f0, f2;
    logic         busy0, done0, valid0, busy2, done2, valid2;
    logic [127:0] tt0, tt2;
    logic [7:0]   oc0, oc2;
    logic         d0a, d0b, d2a, d2b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tt_sweep_capture #(.N(7), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .x(x0), .f_in(f0), .busy(busy0), .done(done0), .valid(valid0),
        .truth_table(tt0), .ones_count(oc0)
    );

    tt_sweep_capture #(.N(7), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .x(x2), .f_in(f2), .busy(busy2), .done(done2), .valid(valid2),
        .truth_table(tt2), .ones_count(oc2)
    );

    // registered function-under-test with two cycles of delay
    always_ff @(posedge clk) begin
        d0a <= fn[x0];
        d0b <= d0a;
        d2a <= fn[x2];
        d2b <= d2a;
    end

    assign f0 = sel_dly ? d0b : fn[x0];
    assign f2 = d2b;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // run dut0 from the current start edge; optional start pulse,
    // abort or reset injection when x reaches the given code
    task automatic wait0(input int p_at, input int a_at, input int r_at,
                         output int cyc, output bit saw);
        bit hit;
        cyc = 0;
        saw = 0;
        hit = 0;
        while (cyc < 2000) begin
            start0 = (p_at >= 0) && (int'(x0) == p_at);
            abort0 = (a_at >= 0) && (int'(x0) == a_at);
            rst    = (r_at >= 0) && (int'(x0) == r_at);
            hit    = abort0 || rst;
            @(posedge clk);
            #1;
            cyc++;
            if (done0) begin
                saw = 1;
                break;
            end
            if (hit) break;
        end
        start0 = 0;
        abort0 = 0;
        rst    = 0;
        if (cyc >= 2000) check("timeout0", 128'(cyc), 128'(0));
    endtask

    task automatic run0(input int p_at, input int a_at, input int r_at,
                        output int cyc, output bit saw);
        @(negedge clk);
        start0 = 1;
        @(posedge clk);
        #1;
        start0 = 0;
        wait0(p_at, a_at, r_at, cyc, saw);
    endtask

    task automatic check_result0(input string tag);
        check({tag, "_tt"}, tt0, fn);
        check({tag, "_ones"}, 128'(oc0), 128'($countones(fn)));
        check({tag, "_valid"}, 128'(valid0), 128'(1));
        check({tag, "_busy"}, 128'(busy0), 128'(0));
    endtask

    initial begin
        int  cyc;
        bit  saw;
        bit  any_done;
        logic [6:0] b;
        logic [127:0] majnet;

        rst = 1; start0 = 0; abort0 = 0; start2 = 0; abort2 = 0;
        sel_dly = 0; fn = '0;
        majnet = 128'heaeaeae8eae8e8a8eae8e8a8e8a8a8a8;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", 128'(x0), 128'(0));
        check("rst_busy", 128'(busy0), 128'(0));
        check("rst_done", 128'(done0), 128'(0));
        check("rst_valid", 128'(valid0), 128'(0));
        check("rst_tt", tt0, 128'(0));
        check("rst_ones", 128'(oc0), 128'(0));
        @(negedge clk);
        rst = 0;

        // 3-input majority built from its definition
        for (int i = 0; i < 128; i++) begin
            b = 7'(i);
            fn[i] = (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2]);
        end
        run0(-1, -1, -1, cyc, saw);
        check("maj3_done", 128'(saw), 128'(1));
        check("maj3_lat", 128'(cyc), 128'(128));
        check("maj3_const", tt0, {16{8'he8}});
        check("maj3_ones", 128'(oc0), 128'(64));
        check_result0("maj3");

        fn = majnet;
        run0(-1, -1, -1, cyc, saw);
        check_result0("majnet");
        check("majnet_ones", 128'(oc0), 128'(64));

        fn = '1;
        run0(-1, -1, -1, cyc, saw);
        check_result0("one");
        check("one_ones", 128'(oc0), 128'(128));
        fn = '0;
        run0(-1, -1, -1, cyc, saw);
        check_result0("zero");

        // stable result while idle
        repeat (7) @(posedge clk);
        #1;
        check("hold_valid", 128'(valid0), 128'(1));
        check("hold_done", 128'(done0), 128'(0));

        // latency-2 function-under-test
        fn = majnet;
        @(negedge clk);
        start2 = 1;
        @(posedge clk);
        #1;
        start2 = 0;
        cyc = 0;
        while (cyc < 3000 && !done2) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("lat2_cyc", 128'(cyc), 128'(384));
        check("lat2_tt", tt2, majnet);
        check("lat2_ones", 128'(oc2), 128'(64));

        sel_dly = 1;
        run0(-1, -1, -1, cyc, saw);
        check("lat0_on_dly_differs", 128'(tt0 == majnet), 128'(0));
        sel_dly = 0;

        // random tables, with start ignored mid-sweep
        for (int k = 0; k < 4; k++) begin
            fn = {$urandom, $urandom, $urandom, $urandom};
            run0((k == 0) ? 10 : int'($urandom_range(1, 120)),
                 -1, -1, cyc, saw);
            check("rnd_lat", 128'(cyc), 128'(128));
            check_result0("rnd");
        end

        // start on the done cycle launches a new sweep
        fn = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start0 = 1;
        @(posedge clk);
        #1;
        check("bb_valid_drop", 128'(valid0), 128'(0));
        check("bb_busy", 128'(busy0), 128'(1));
        wait0(-1, -1, -1, cyc, saw);
        check("bb_lat", 128'(cyc), 128'(128));
        check_result0("bb");

        // abort at idx 40
        fn = {$urandom, $urandom, $urandom, $urandom};
        run0(-1, 40, -1, cyc, saw);
        check("abort_nodone", 128'(saw), 128'(0));
        check("abort_busy", 128'(busy0), 128'(0));
        check("abort_valid", 128'(valid0), 128'(0));
        check("abort_x", 128'(x0), 128'(0));
        any_done = 0;
        repeat (140) begin
            @(posedge clk);
            #1;
            any_done |= done0;
        end
        check("abort_no_late_done", 128'(any_done), 128'(0));
        run0(-1, -1, -1, cyc, saw);
        check("after_abort_lat", 128'(cyc), 128'(128));
        check_result0("after_abort");

        // abort together with start in idle: not started
        @(negedge clk);
        start0 = 1;
        abort0 = 1;
        @(posedge clk);
        #1;
        start0 = 0;
        abort0 = 0;
        check("abort_start_busy", 128'(busy0), 128'(0));
        check("abort_start_valid", 128'(valid0), 128'(1));

        // reset mid-sweep at idx 70
        run0(-1, -1, 70, cyc, saw);
        check("rst70_busy", 128'(busy0), 128'(0));
        check("rst70_valid", 128'(valid0), 128'(0));
        check("rst70_done", 128'(done0), 128'(0));
        check("rst70_x", 128'(x0), 128'(0));
        check("rst70_tt", tt0, 128'(0));
        check("rst70_ones", 128'(oc0), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
